// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
//   Frequency-sweep sequencer for a DDS phase-increment port. On start it
//   latches a sweep configuration, then repeatedly presents a phase
//   increment on an AXI-stream beat, holds it for a dwell period, and steps
//   the increment by cfg_step until it would exceed cfg_stop_inc. The sweep
//   either finishes (single shot) or restarts from cfg_start_inc.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, abort        single-cycle sweep begin / terminate requests
//   cfg_start_inc       first phase increment
//   cfg_step            unsigned increment added per step
//   cfg_stop_inc        last permitted phase increment
//   cfg_dwell           each step is held in DWELL for cfg_dwell+1 cycles
//   cfg_repeat          1 = restart after the last step, 0 = single sweep
//   phase_tvalid/tdata  AXI-stream beat toward the DDS phase port
//   phase_tready        DDS ready (tie high if the core has none)
//   busy                high whenever not IDLE
//   step_strobe         pulse on each accepted beat
//   sweep_done          pulse when a single sweep completes
module dds_sweep_ctrl #(
  parameter int PHASE_W = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] cfg_start_inc,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [PHASE_W-1:0] cfg_stop_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  output logic               phase_tvalid,
  output logic [PHASE_W-1:0] phase_tdata,
  input  logic               phase_tready,
  output logic               busy,
  output logic               step_strobe,
  output logic               sweep_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PHASE_W-1:0] r_cur_inc;
  logic [DWELL_W-1:0] r_dwell_cnt;

  logic [PHASE_W-1:0] r_start_inc;
  logic [PHASE_W-1:0] r_step;
  logic [PHASE_W-1:0] r_stop_inc;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_repeat;

  logic [PHASE_W:0]   w_next_sum;
  logic               w_out_of_range;
  logic               w_latch;
  logic               w_accept;
  logic               w_dwell_zero;

  // One extra bit keeps the carry so a sum that wraps past 2^PHASE_W is
  // treated as out of range instead of looking like a small increment.
  assign w_next_sum     = {1'b0, r_cur_inc} + {1'b0, r_step};
  assign w_out_of_range = w_next_sum[PHASE_W] ||
                          (w_next_sum[PHASE_W-1:0] > r_stop_inc);

  assign w_latch      = (r_state == S_IDLE) && start && !abort;
  // abort wins over a handshake that would otherwise complete this cycle
  assign w_accept     = (r_state == S_LOAD) && phase_tready && !abort;
  assign w_dwell_zero = (r_dwell_cnt == '0);

  always_comb begin
    w_state_nxt  = r_state;
    phase_tvalid = 1'b0;
    phase_tdata  = r_cur_inc;
    busy         = (r_state != S_IDLE);
    step_strobe  = 1'b0;
    sweep_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_latch) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        phase_tvalid = 1'b1;
        step_strobe  = w_accept;
        if (abort)             w_state_nxt = S_IDLE;
        else if (phase_tready) w_state_nxt = S_DWELL;
      end
      S_DWELL: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_dwell_zero) begin
          if (!w_out_of_range || r_repeat) w_state_nxt = S_LOAD;
          else                             w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        sweep_done  = !abort;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_inc   <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_cur_inc <= cfg_start_inc;
      if (w_accept) r_dwell_cnt <= r_dwell;
      if ((r_state == S_DWELL) && !abort) begin
        if (!w_dwell_zero) begin
          r_dwell_cnt <= r_dwell_cnt - 1'b1;
        end else if (!w_out_of_range) begin
          r_cur_inc <= w_next_sum[PHASE_W-1:0];
        end else if (r_repeat) begin
          r_cur_inc <= r_start_inc;
        end
      end
    end
  end

  // Configuration snapshot: taken only when a sweep starts, so later cfg_*
  // changes do not disturb a sweep in progress.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_start_inc <= cfg_start_inc;
      r_step      <= cfg_step;
      r_stop_inc  <= cfg_stop_inc;
      r_dwell     <= cfg_dwell;
      r_repeat    <= cfg_repeat;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] cfg_start_inc;
  logic [31:0] cfg_step;
  logic [31:0] cfg_stop_inc;
  logic [15:0] cfg_dwell;
  logic        cfg_repeat;
  logic        phase_tvalid;
  logic [31:0] phase_tdata;
  logic        phase_tready;
  logic        busy;
  logic        step_strobe;
  logic        sweep_done;

  int checks   = 0;
  int failures = 0;

  dds_sweep_ctrl #(.PHASE_W(32), .DWELL_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_start_inc (cfg_start_inc),
    .cfg_step      (cfg_step),
    .cfg_stop_inc  (cfg_stop_inc),
    .cfg_dwell     (cfg_dwell),
    .cfg_repeat    (cfg_repeat),
    .phase_tvalid  (phase_tvalid),
    .phase_tdata   (phase_tdata),
    .phase_tready  (phase_tready),
    .busy          (busy),
    .step_strobe   (step_strobe),
    .sweep_done    (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; this samples all outputs at
  // the following falling edge and then advances to just after the next
  // rising edge.
  task automatic ex(input string tag, input logic v, input logic [31:0] d,
                    input logic s, input logic b, input logic dn);
    @(negedge clk);
    chk({tag, ".tvalid"}, {31'b0, phase_tvalid}, {31'b0, v});
    chk({tag, ".tdata"},  phase_tdata, d);
    chk({tag, ".strobe"}, {31'b0, step_strobe}, {31'b0, s});
    chk({tag, ".busy"},   {31'b0, busy}, {31'b0, b});
    chk({tag, ".done"},   {31'b0, sweep_done}, {31'b0, dn});
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] st, input logic [31:0] sp,
                     input logic [15:0] dw, input logic rp);
    cfg_start_inc = s;
    cfg_step      = st;
    cfg_stop_inc  = sp;
    cfg_dwell     = dw;
    cfg_repeat    = rp;
  endtask

  initial begin
    logic [31:0] rep_seq [5];
    rep_seq[0] = 32'd100; rep_seq[1] = 32'd150; rep_seq[2] = 32'd200;
    rep_seq[3] = 32'd100; rep_seq[4] = 32'd150;

    rst = 1'b1; start = 1'b0; abort = 1'b0; phase_tready = 1'b1;
    cfg(32'd0, 32'd0, 32'd0, 16'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ex("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 1: single sweep 100,150,200 with dwell 2; cfg changed after latch
    cfg(32'd100, 32'd50, 32'd200, 16'd2, 1'b0);
    start = 1'b1;
    ex("s1_start", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    cfg(32'd7, 32'd1, 32'd1000, 16'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      ex($sformatf("s1_beat%0d", k), 1'b1, 32'd100 + 32'd50 * k, 1'b1, 1'b1, 1'b0);
      for (int j = 0; j < 3; j++)
        ex($sformatf("s1_dw%0d_%0d", k, j), 1'b0, 32'd100 + 32'd50 * k, 1'b0, 1'b1, 1'b0);
    end
    ex("s1_done", 1'b0, 32'd200, 1'b0, 1'b1, 1'b1);
    ex("s1_idle", 1'b0, 32'd200, 1'b0, 1'b0, 1'b0);

    // Scenario 2: repeating sweep, then abort during dwell
    cfg(32'd100, 32'd50, 32'd200, 16'd2, 1'b1);
    start = 1'b1;
    ex("s2_start", 1'b0, 32'd200, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ex($sformatf("s2_beat%0d", k), 1'b1, rep_seq[k], 1'b1, 1'b1, 1'b0);
      if (k < 4)
        for (int j = 0; j < 3; j++)
          ex($sformatf("s2_dw%0d_%0d", k, j), 1'b0, rep_seq[k], 1'b0, 1'b1, 1'b0);
    end
    abort = 1'b1;
    ex("s2_abort", 1'b0, 32'd150, 1'b0, 1'b1, 1'b0);
    abort = 1'b0;
    ex("s2_idle", 1'b0, 32'd150, 1'b0, 1'b0, 1'b0);
    ex("s2_idle2", 1'b0, 32'd150, 1'b0, 1'b0, 1'b0);

    // Scenario 3: backpressure in LOAD, then abort over a pending handshake
    cfg(32'd10, 32'd5, 32'd20, 16'd1, 1'b0);
    start = 1'b1;
    ex("s3_start", 1'b0, 32'd150, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    phase_tready = 1'b0;
    for (int k = 0; k < 5; k++)
      ex($sformatf("s3_stall%0d", k), 1'b1, 32'd10, 1'b0, 1'b1, 1'b0);
    phase_tready = 1'b1;
    ex("s3_accept", 1'b1, 32'd10, 1'b1, 1'b1, 1'b0);
    ex("s3_dw0", 1'b0, 32'd10, 1'b0, 1'b1, 1'b0);
    ex("s3_dw1", 1'b0, 32'd10, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    ex("s3_abort_hs", 1'b1, 32'd15, 1'b0, 1'b1, 1'b0);
    abort = 1'b0;
    ex("s3_idle", 1'b0, 32'd15, 1'b0, 1'b0, 1'b0);

    // Scenario 4: carry out of the phase word ends the sweep
    cfg(32'hFFFF_FF00, 32'h0000_0200, 32'hFFFF_FFFF, 16'd1, 1'b0);
    start = 1'b1;
    ex("s4_start", 1'b0, 32'd15, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    ex("s4_beat", 1'b1, 32'hFFFF_FF00, 1'b1, 1'b1, 1'b0);
    ex("s4_dw0", 1'b0, 32'hFFFF_FF00, 1'b0, 1'b1, 1'b0);
    ex("s4_dw1", 1'b0, 32'hFFFF_FF00, 1'b0, 1'b1, 1'b0);
    ex("s4_done", 1'b0, 32'hFFFF_FF00, 1'b0, 1'b1, 1'b1);
    ex("s4_idle", 1'b0, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0);

    // Scenario 5: start above stop, dwell 0
    cfg(32'd300, 32'd50, 32'd200, 16'd0, 1'b0);
    start = 1'b1;
    ex("s5_start", 1'b0, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    ex("s5_beat", 1'b1, 32'd300, 1'b1, 1'b1, 1'b0);
    ex("s5_dw", 1'b0, 32'd300, 1'b0, 1'b1, 1'b0);
    ex("s5_done", 1'b0, 32'd300, 1'b0, 1'b1, 1'b1);
    ex("s5_idle", 1'b0, 32'd300, 1'b0, 1'b0, 1'b0);

    // start together with abort in IDLE stays idle
    cfg(32'd100, 32'd50, 32'd200, 16'd2, 1'b0);
    start = 1'b1; abort = 1'b1;
    ex("sa_both", 1'b0, 32'd300, 1'b0, 1'b0, 1'b0);
    start = 1'b0; abort = 1'b0;
    ex("sa_idle", 1'b0, 32'd300, 1'b0, 1'b0, 1'b0);

    // Scenario 6: start while busy is ignored, reset during dwell
    start = 1'b1;
    ex("s6_start", 1'b0, 32'd300, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    ex("s6_beat", 1'b1, 32'd100, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    cfg(32'd555, 32'd1, 32'd600, 16'd0, 1'b1);
    ex("s6_dw0", 1'b0, 32'd100, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    ex("s6_dw1", 1'b0, 32'd100, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    ex("s6_dw2", 1'b0, 32'd100, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    ex("s6_rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    ex("s6_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
